// File: rtl/int_ctrl_if.sv
// ============================================================================
// Module      : int_ctrl_if
// Description : Event-line, control and request/vector bundle for int_ctrl.
//               HOLDOFF exists only when INT_CTRL_HOLDOFF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_ctrl_if #(
  parameter int NCH       = 8,
  parameter int VW        = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int HOLDOFF_W = 8
);
  logic [NCH-1:0]       IRQ_IN;
  logic [NCH-1:0]       ENABLE;
  logic [2*NCH-1:0]     MODE;
  logic [NCH-1:0]       CLEAR;
  logic                 ACK;
  logic [NCH-1:0]       PENDING;
  logic                 IRQ_OUT;
  logic [VW-1:0]        VECTOR;
  logic                 VALID;
`ifdef INT_CTRL_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] HOLDOFF;
`endif

  modport master (
    output IRQ_IN, ENABLE, MODE, CLEAR, ACK,
`ifdef INT_CTRL_HOLDOFF_EN
    output HOLDOFF,
`endif
    input  PENDING, IRQ_OUT, VECTOR, VALID
  );

  modport slave (
    input  IRQ_IN, ENABLE, MODE, CLEAR, ACK,
`ifdef INT_CTRL_HOLDOFF_EN
    input  HOLDOFF,
`endif
    output PENDING, IRQ_OUT, VECTOR, VALID
  );
endinterface

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module      : int_ctrl
// Description : Multi-channel interrupt source/aggregator with synchronisers,
//               programmable trigger modes, sticky pending bits and a
//               lowest-index-wins registered IRQ_OUT/VECTOR.
//               Optional macro INT_CTRL_HOLDOFF_EN adds post-ACK IRQ holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VW          = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int HOLDOFF_W   = 8
) (
  input  wire logic  CLK,
  input  wire logic  RESETn,
  int_ctrl_if.slave  bus
);

  localparam logic [1:0] c_MODE_LEVEL = 2'b00;
  localparam logic [1:0] c_MODE_RISE  = 2'b01;
  localparam logic [1:0] c_MODE_FALL  = 2'b10;

  logic [NCH-1:0] r_sync [SYNC_STAGES];
  logic [NCH-1:0] r_prev;
  logic [NCH-1:0] r_pending;
  logic           r_valid;
  logic [VW-1:0]  r_vector;

  logic [NCH-1:0] w_s;
  logic [NCH-1:0] w_event;
  logic [NCH-1:0] w_set;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_act;
  logic           w_valid;
  logic [VW-1:0]  w_vector;
  logic           w_ack_ok;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_ack_ok = bus.ACK & r_valid;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= bus.IRQ_IN;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s;
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [1:0] w_mode;
      assign w_mode = bus.MODE[2*g +: 2];

      always_comb begin
        w_event[g] = w_s[g] ^ r_prev[g];
        case (w_mode)
          c_MODE_LEVEL: w_event[g] = w_s[g];
          c_MODE_RISE:  w_event[g] = w_s[g] & ~r_prev[g];
          c_MODE_FALL:  w_event[g] = ~w_s[g] & r_prev[g];
          default:      w_event[g] = w_s[g] ^ r_prev[g];
        endcase
      end

      // ACK only ever clears the channel that was on the registered VECTOR
      assign w_clr[g] = bus.CLEAR[g] | (w_ack_ok & (r_vector == VW'(g)));
    end
  endgenerate

  assign w_set = w_event & bus.ENABLE;

  // Set is OR'd after the clear so a coincident event is never lost
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_pending <= '0;
    else         r_pending <= w_set | (r_pending & ~w_clr);
  end

  assign w_act   = r_pending & bus.ENABLE;
  assign w_valid = |w_act;

  always_comb begin
    w_vector = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_act[i]) w_vector = VW'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_valid  <= 1'b0;
      r_vector <= '0;
    end else begin
      r_valid  <= w_valid;
      r_vector <= w_vector;
    end
  end

`ifdef INT_CTRL_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] r_hold;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)            r_hold <= '0;
    else if (w_ack_ok)      r_hold <= bus.HOLDOFF;
    else if (r_hold != '0)  r_hold <= r_hold - 1'b1;
  end

  assign bus.IRQ_OUT = r_valid & (r_hold == '0);
`else
  assign bus.IRQ_OUT = r_valid;
`endif

  assign bus.PENDING = r_pending;
  assign bus.VALID   = r_valid;
  assign bus.VECTOR  = r_vector;

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// Module      : tb_int_ctrl
// Description : Directed self-checking bench for int_ctrl (NCH=8, 2 sync stages).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;

  localparam int c_NCH = 8;
  localparam int c_VW  = 3;
  localparam int c_HW  = 8;

  logic CLK;
  logic RESETn;
  int   n_checks;
  int   n_errors;

  int_ctrl_if #(.NCH(c_NCH), .VW(c_VW), .HOLDOFF_W(c_HW)) bus ();

  int_ctrl #(
    .NCH(c_NCH), .SYNC_STAGES(2), .VW(c_VW), .HOLDOFF_W(c_HW)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic ack_pulse();
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    RESETn     = 1'b0;
    bus.IRQ_IN = '0;
    bus.ENABLE = '0;
    bus.MODE   = 16'h5555;
    bus.CLEAR  = '0;
    bus.ACK    = 1'b0;
`ifdef INT_CTRL_HOLDOFF_EN
    bus.HOLDOFF = '0;
`endif
    tick(3);
    chk("rst_pending", 32'(bus.PENDING), 32'h0);
    chk("rst_irq",     32'(bus.IRQ_OUT), 32'h0);
    chk("rst_vector",  32'(bus.VECTOR),  32'h0);
    chk("rst_valid",   32'(bus.VALID),   32'h0);
    RESETn = 1'b1;
    tick(2);

    // ch3 rising: edge k -> PENDING at k+2 -> IRQ/VECTOR at k+3
    bus.ENABLE = 8'h08;
    bus.IRQ_IN = 8'h08;
    tick(2);
    chk("ch3_pend_k1", 32'(bus.PENDING), 32'h00);
    tick();
    chk("ch3_pend_k2", 32'(bus.PENDING), 32'h08);
    chk("ch3_irq_k2",  32'(bus.IRQ_OUT), 32'h0);
    tick();
    chk("ch3_irq_k3",  32'(bus.IRQ_OUT), 32'h1);
    chk("ch3_vec_k3",  32'(bus.VECTOR),  32'h3);
    ack_pulse();
    chk("ch3_ack_pend", 32'(bus.PENDING), 32'h00);
    tick();
    chk("ch3_ack_irq",  32'(bus.IRQ_OUT), 32'h0);
    chk("ch3_ack_valid", 32'(bus.VALID),  32'h0);
    bus.IRQ_IN = '0;
    tick(4);

    // ch1 + ch5 together: lowest index first
    bus.ENABLE = 8'hFF;
    bus.IRQ_IN = 8'h22;
    tick(4);
    chk("pri_pend", 32'(bus.PENDING), 32'h22);
    chk("pri_vec1", 32'(bus.VECTOR),  32'h1);
    ack_pulse();
    tick();
    chk("pri_vec5",  32'(bus.VECTOR), 32'h5);
    chk("pri_valid", 32'(bus.VALID),  32'h1);
    ack_pulse();
    tick();
    chk("pri_none_valid", 32'(bus.VALID),   32'h0);
    chk("pri_none_irq",   32'(bus.IRQ_OUT), 32'h0);
    bus.IRQ_IN = '0;
    tick(4);

    // ch2 level: clear while input high re-sets
    bus.MODE   = 16'h5545;
    bus.IRQ_IN = 8'h04;
    tick(4);
    chk("lvl_vec", 32'(bus.VECTOR), 32'h2);
    bus.CLEAR = 8'h04;
    tick();
    bus.CLEAR = '0;
    chk("lvl_clr_high", 32'(bus.PENDING[2]), 32'h1);
    bus.IRQ_IN = '0;
    tick(3);
    chk("lvl_sticky", 32'(bus.PENDING[2]), 32'h1);
    bus.CLEAR = 8'h04;
    tick();
    bus.CLEAR = '0;
    chk("lvl_clr_low", 32'(bus.PENDING[2]), 32'h0);
    tick(2);

    // ch0 both edges
    bus.MODE   = 16'h5557;
    bus.IRQ_IN = 8'h01;
    tick(3);
    chk("both_rise", 32'(bus.PENDING), 32'h01);
    bus.CLEAR = 8'h01;
    tick();
    bus.CLEAR = '0;
    chk("both_clr1", 32'(bus.PENDING), 32'h00);
    bus.IRQ_IN = '0;
    tick(3);
    chk("both_fall", 32'(bus.PENDING), 32'h01);
    bus.CLEAR = 8'h01;
    tick();
    bus.CLEAR = '0;
    chk("both_clr2", 32'(bus.PENDING), 32'h00);
    // Event lands on the same edge as CLEAR[0]: set must win
    bus.IRQ_IN = 8'h01;
    tick(2);
    bus.CLEAR = 8'h01;
    tick();
    bus.CLEAR = '0;
    chk("both_set_wins", 32'(bus.PENDING), 32'h01);
    tick();
    chk("both_hold", 32'(bus.PENDING), 32'h01);

    // ENABLE low retains PENDING but hides it; ACK with VALID=0 is ignored
    bus.ENABLE = '0;
    tick(2);
    chk("dis_irq",   32'(bus.IRQ_OUT), 32'h0);
    chk("dis_valid", 32'(bus.VALID),   32'h0);
    ack_pulse();
    tick();
    chk("dis_ack_ign", 32'(bus.PENDING), 32'h01);
    bus.ENABLE = 8'hFF;
    tick(2);
    chk("reen_irq", 32'(bus.IRQ_OUT), 32'h1);

    // Asynchronous reset mid-cycle
    #2 RESETn = 1'b0;
    #1;
    chk("arst_pend", 32'(bus.PENDING), 32'h00);
    chk("arst_irq",  32'(bus.IRQ_OUT), 32'h0);
    bus.IRQ_IN = '0;
    tick(2);
    RESETn = 1'b1;
    tick(2);

`ifdef INT_CTRL_HOLDOFF_EN
    bus.MODE    = 16'h5555;
    bus.ENABLE  = 8'hFF;
    bus.HOLDOFF = 8'd4;
    bus.IRQ_IN  = 8'h03;
    tick(4);
    chk("ho_vec0", 32'(bus.VECTOR), 32'h0);
    ack_pulse();
    for (int i = 0; i < 4; i++) begin
      chk("ho_low",   32'(bus.IRQ_OUT), 32'h0);
      chk("ho_valid", 32'(bus.VALID),   32'h1);
      tick();
    end
    chk("ho_high", 32'(bus.IRQ_OUT), 32'h1);
    chk("ho_vec1", 32'(bus.VECTOR),  32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
